riscv_dmem_responder: RTL and testbench

- Data-side responder for the RV32I pipeline core: terminates the core's store/load port (memwrite, dataadr, writedata) and returns readdata.
- Word RAM with byte-strobed writes and combinational read, matching the core's single-cycle memory stage.
- MMIO test-status region: TOHOST pass/fail state machine, saturating store counter, and a signature FIFO that captures stores to a configurable window. Benches and FPGA builds read results from these instead of snooping the bus.

---
 rtl/riscv_tb_pkg.sv | 7 +
 rtl/sync_fifo.sv | 35 +++
 rtl/riscv_dmem_responder.sv | 90 +++++++++
 tb/tb_riscv_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_tb_pkg.sv
// riscv_tb_pkg: shared MMIO offsets, TOHOST state encoding and pass code
package riscv_tb_pkg;
  localparam logic [7:0] TOHOST_OFF = 8'h00;
  localparam logic [7:0] STCNT_OFF = 8'h04;
  localparam logic [31:0] PASS_CODE = 32'd1;
  typedef enum logic [1:0] {RUN = 2'd0, PASS = 2'd1, FAIL = 2'd2} tohost_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; head reads 0 when empty
module sync_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  // a pop frees the slot the same cycle, so a full FIFO still accepts the push
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
endmodule

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: byte-strobed data RAM plus TOHOST/store-count/signature MMIO
module riscv_dmem_responder
  import riscv_tb_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter string       MEM_INIT  = "",
  parameter logic [15:0] MMIO_HI   = 16'hFFFF,
  parameter logic [31:0] SIG_LO    = 32'h0000_0258,
  parameter logic [31:0] SIG_HI    = 32'h0000_027C,
  parameter int          SIG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic [3:0]  be,
  output logic [31:0] readdata,
  output logic        test_done,
  output logic        test_pass,
  output logic [30:0] fail_code,
  output logic [15:0] store_count,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [15:0] sig_addr,
  output logic [31:0] sig_data,
  output logic        sig_overflow
);
  logic [31:0] ram [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [31:0] word, merged, word_adr;
  logic mmio, ram_st, in_win, sig_push, sig_pop, fifo_full, fifo_empty, tohost_wr;
  tohost_e state, state_nx;
  logic [30:0] fc_nx;
  assign mmio = dataadr[31:16] == MMIO_HI;
  assign idx = dataadr[ADDR_W+1:2];
  assign word = ram[idx];
  assign ram_st = memwrite & ~mmio;
  assign word_adr = {dataadr[31:2], 2'b00};
  assign in_win = (word_adr >= SIG_LO) && (word_adr <= SIG_HI);
  assign tohost_wr = memwrite & mmio & (dataadr[15:0] == {8'h00, TOHOST_OFF}) & (be == 4'hF);
  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = writedata[8*i +: 8];
  end
  always_ff @(posedge clk)
    if (ram_st & rst_n) ram[idx] <= merged;
  assign readdata = !mmio ? word :
                    (dataadr[15:0] == {8'h00, TOHOST_OFF}) ? {test_pass, test_done, 30'b0} :
                    (dataadr[15:0] == {8'h00, STCNT_OFF}) ? {16'b0, store_count} : '0;
  always_comb begin
    state_nx = state;
    fc_nx = fail_code;
    if (tohost_wr && state == RUN) begin
      if (writedata == PASS_CODE) state_nx = PASS;
      else if (writedata[0]) begin
        state_nx = FAIL;
        fc_nx = writedata[31:1];
      end
    end
  end
  assign test_done = state != RUN;
  assign test_pass = state == PASS;
  assign sig_push = ram_st & in_win;
  assign sig_pop = sig_valid & sig_ready;
  assign sig_valid = ~fifo_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fail_code <= '0;
      store_count <= '0;
      sig_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      fail_code <= fc_nx;
      if (ram_st && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (sig_push & fifo_full & ~sig_pop) sig_overflow <= 1'b1;
    end
  sync_fifo #(.W(48), .DEPTH(SIG_DEPTH)) u_sig_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sig_push),
    .pop   (sig_pop),
    .din   ({dataadr[15:0], merged}),
    .dout  ({sig_addr, sig_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: vector table, corner sequences and randomized model check
module tb_riscv_dmem_responder;
  logic clk = 0, rst_n = 0, memwrite = 0, sig_ready = 0;
  logic [31:0] dataadr = 0, writedata = 0;
  logic [3:0] be = 0;
  logic [31:0] readdata, sig_data;
  logic test_done, test_pass, sig_valid, sig_overflow;
  logic [30:0] fail_code;
  logic [15:0] store_count, sig_addr;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder dut (
    .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .be(be), .readdata(readdata), .test_done(test_done),
    .test_pass(test_pass), .fail_code(fail_code), .store_count(store_count),
    .sig_valid(sig_valid), .sig_ready(sig_ready), .sig_addr(sig_addr),
    .sig_data(sig_data), .sig_overflow(sig_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic r);
    memwrite = mw; dataadr = a; writedata = wd; be = b; sig_ready = r;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
  endtask

  typedef struct {
    logic mw; logic [31:0] a; logic [31:0] wd; logic [3:0] b; logic r;
    logic [31:0] ca; logic [31:0] rd; logic [15:0] cnt; logic done; logic pass;
    logic [30:0] fc; logic valid; logic [15:0] sa; logic [31:0] sd;
  } vec_t;
  vec_t tbl[9];

  // behavioural model: word array, result code, store tally, queue of captures
  logic [31:0] mram [256];
  int mstate, mcnt;
  logic [30:0] mfc;
  logic [47:0] mq[$];
  bit movf;

  task automatic mstep(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic r, input bit chk_rd);
    logic [31:0] exp_rd, w;
    bit pop, win, io;
    drive(mw, a, wd, b, r);
    #1;
    io = a[31:16] == 16'hFFFF;
    exp_rd = !io ? mram[a[9:2]] :
             a[15:0] == 16'h0000 ? {mstate == 1, mstate != 0, 30'b0} :
             a[15:0] == 16'h0004 ? 32'(mcnt) : 32'h0;
    if (chk_rd) chk("rand readdata", readdata, exp_rd);
    @(posedge clk);
    pop = r && mq.size() > 0;
    win = 0;
    if (mw && !io) begin
      w = mram[a[9:2]];
      for (int k = 0; k < 4; k++) if (b[k]) w[8*k +: 8] = wd[8*k +: 8];
      mram[a[9:2]] = w;
      if (mcnt < 65535) mcnt++;
      win = ((a & ~32'h3) >= 32'h258) && ((a & ~32'h3) <= 32'h27C);
    end
    if (pop) void'(mq.pop_front());
    if (win) begin
      if (mq.size() == 8) movf = 1;
      else mq.push_back({a[15:0], w});
    end
    if (mw && a == 32'hFFFF0000 && b == 4'hF && mstate == 0) begin
      if (wd == 1) mstate = 1;
      else if (wd[0]) begin mstate = 2; mfc = wd[31:1]; end
    end
    @(negedge clk);
    chk("rand status", {test_done, test_pass, fail_code}, {mstate != 0, mstate == 1, mfc});
    chk("rand count", store_count, 16'(mcnt));
    chk("rand head", {sig_valid, sig_addr, sig_data}, mq.size() > 0 ? {1'b1, mq[0]} : 49'h0);
    chk("rand overflow", sig_overflow, movf);
  endtask

  initial begin
    logic [31:0] a;
    int idx;
    tbl[0] = '{1, 32'h258, 32'hABCDE000, 4'hF, 0, 32'h258, 32'hABCDE000, 1, 0, 0, 0, 1, 16'h0258, 32'hABCDE000};
    tbl[1] = '{1, 32'h25C, 32'd4100, 4'hF, 0, 32'h25C, 32'h00001004, 2, 0, 0, 0, 1, 16'h0258, 32'hABCDE000};
    tbl[2] = '{0, 32'h0, 32'h0, 4'h0, 1, 32'h258, 32'hABCDE000, 2, 0, 0, 0, 1, 16'h025C, 32'h00001004};
    tbl[3] = '{0, 32'h0, 32'h0, 4'h0, 1, 32'hFFFF0004, 32'h2, 2, 0, 0, 0, 0, 16'h0, 32'h0};
    tbl[4] = '{1, 32'h100, 32'h11223344, 4'hF, 0, 32'h100, 32'h11223344, 3, 0, 0, 0, 0, 16'h0, 32'h0};
    tbl[5] = '{1, 32'h100, 32'h0000AB00, 4'b0010, 0, 32'h100, 32'h1122AB44, 4, 0, 0, 0, 0, 16'h0, 32'h0};
    tbl[6] = '{1, 32'hFFFF0000, 32'd1, 4'hF, 0, 32'hFFFF0000, 32'hC0000000, 4, 1, 1, 0, 0, 16'h0, 32'h0};
    tbl[7] = '{1, 32'hFFFF0000, 32'd7, 4'hF, 0, 32'hFFFF0000, 32'hC0000000, 4, 1, 1, 0, 0, 16'h0, 32'h0};
    tbl[8] = '{0, 32'h0, 32'h0, 4'h0, 0, 32'hFFFF0008, 32'h0, 4, 1, 1, 0, 0, 16'h0, 32'h0};

    do_reset;
    chk("reset state", {test_done, test_pass, fail_code, store_count, sig_valid, sig_overflow}, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].mw, tbl[i].a, tbl[i].wd, tbl[i].b, tbl[i].r);
      tick;
      drive(0, tbl[i].ca, 0, 0, 0);
      #1;
      chk($sformatf("vec%0d readdata", i), readdata, tbl[i].rd);
      chk($sformatf("vec%0d status", i), {test_done, test_pass, fail_code}, {tbl[i].done, tbl[i].pass, tbl[i].fc});
      chk($sformatf("vec%0d count", i), store_count, tbl[i].cnt);
      chk($sformatf("vec%0d head", i), {sig_valid, sig_addr, sig_data}, {tbl[i].valid, tbl[i].sa, tbl[i].sd});
    end

    // TOHOST fail path; partial-strobe write must be ignored
    do_reset;
    drive(1, 32'hFFFF0000, 32'd7, 4'h1, 0);
    tick;
    chk("tohost be!=F", {test_done, test_pass}, 2'b00);
    drive(1, 32'hFFFF0000, 32'd7, 4'hF, 0);
    tick;
    chk("tohost fail", {test_done, test_pass, fail_code}, {2'b10, 31'd3});
    drive(0, 32'hFFFF0000, 0, 0, 0);
    #1;
    chk("tohost fail readdata", readdata, 32'h40000000);

    // fill, push+pop while full, overflow, then drain in order
    do_reset;
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h258 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF, 0);
      tick;
    end
    chk("fifo full head", {sig_valid, sig_addr, sig_data, sig_overflow}, {1'b1, 16'h0258, 32'hA0000000, 1'b0});
    drive(1, 32'h27C, 32'hA0000008, 4'hF, 1);
    tick;
    chk("full push+pop", {sig_valid, sig_addr, sig_data, sig_overflow}, {1'b1, 16'h025C, 32'hA0000001, 1'b0});
    drive(1, 32'h258, 32'h0000DEAD, 4'hF, 0);
    tick;
    chk("overflow sticky", sig_overflow, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      chk($sformatf("drain%0d", k), {sig_valid, sig_addr, sig_data},
          {1'b1, k < 7 ? 16'h025C + 16'(4 * k) : 16'h027C, 32'hA0000001 + 32'(k)});
      tick;
    end
    chk("drained", {sig_valid, sig_overflow, store_count}, {2'b01, 16'd10});

    // async reset mid-cycle keeps RAM only
    do_reset;
    drive(1, 32'h258, 32'hC0000000, 4'hF, 0); tick;
    drive(1, 32'h25C, 32'hC0000001, 4'hF, 0); tick;
    drive(1, 32'h104, 32'hC0000002, 4'hF, 0); tick;
    drive(1, 32'hFFFF0000, 32'd1, 4'hF, 0); tick;
    chk("pre-reset", {store_count, sig_valid, test_done}, {16'd3, 2'b11});
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async reset", {store_count, sig_valid, test_done, test_pass, sig_overflow}, 0);
    tick;
    rst_n = 1;
    drive(0, 32'h258, 0, 0, 0); #1 chk("ram kept 258", readdata, 32'hC0000000);
    drive(0, 32'h25C, 0, 0, 0); #1 chk("ram kept 25C", readdata, 32'hC0000001);
    drive(0, 32'h104, 0, 0, 0); #1 chk("ram kept 104", readdata, 32'hC0000002);

    // randomized run against the model
    do_reset;
    mstate = 0; mcnt = 0; mfc = 0; movf = 0; mq.delete();
    for (int i = 140; i < 172; i++) mstep(1, 32'(i) << 2, $urandom, 4'hF, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        a = 32'hFFFF0000 | (32'($urandom_range(0, 2)) << 2);
        mstep($urandom_range(0, 2) != 0, a, $urandom_range(0, 3) == 0 ? 32'd1 : $urandom,
              $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1);
      end else begin
        idx = $urandom_range(140, 171);
        a = (32'(idx) << 2) | 32'($urandom_range(0, 3)) | ($urandom_range(0, 3) == 0 ? 32'h1000 : 32'h0);
        mstep($urandom_range(0, 2) != 0, a, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
